rc4_cipher_packer: RTL and testbench

Downstream stage of the RC4 core. Consumes the core's ciphertext byte stream on its ap_fifo write interface (din/full_n/write), packs bytes little-endian into 32-bit words, buffers them in a small word FIFO and presents them on a valid/ready word stream with byte-keep and last-beat marking. One transfer is framed by a programmed byte count matching the core's plaintext size.

---
 rtl/rc4_cipher_packer.sv | 172 +++++++++++++++++
 tb/tb_rc4_cipher_packer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_cipher_packer.sv
// Word FIFO holding packed beats; head entry drives the output directly.
// Latency: a pushed entry is visible on rd_vld the cycle after the push edge.
// Backpressure: caller must not push when count == DEPTH; head holds while !rd_rdy.
module rc4_word_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign rd_vld = (count != '0);
    assign pop    = rd_vld && rd_rdy;
    // Gate the head so an empty FIFO presents all-zero data.
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW + 1)'(wr_vld) - (AW + 1)'(pop);
        end
    end
endmodule

// Packs RC4 ciphertext bytes little-endian into 32-bit words with keep/last framing.
// Latency: m_tvalid rises the cycle after the edge accepting a word's last byte.
// Backpressure: full_n falls when the word FIFO is full; beats hold while !m_tready.
module rc4_cipher_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        start,
    input  logic [31:0] size_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] byte_count,
    input  logic [7:0]  ciphertext_in_V_din,
    output logic        ciphertext_in_V_full_n,
    input  logic        ciphertext_in_V_write,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [31:0]   size_q;
    logic [31:0]   asm_q;
    logic [31:0]   asm_next;
    logic [31:0]   bc_next;
    logic [3:0]    push_keep;
    logic [1:0]    lane;
    logic          accept;
    logic          final_byte;
    logic          push_vld;
    logic [36:0]   push_dat;
    logic [CW-1:0] fifo_count;

    assign busy = (state != S_IDLE);
    assign ciphertext_in_V_full_n = (state == S_RUN) && (fifo_count < CW'(FIFO_DEPTH))
                                    && (byte_count < size_q);

    assign accept     = ciphertext_in_V_write && ciphertext_in_V_full_n;
    assign lane       = byte_count[1:0];
    assign bc_next    = byte_count + 32'd1;
    assign final_byte = accept && (bc_next == size_q);
    assign push_vld   = accept && ((lane == 2'd3) || final_byte);
    assign push_dat   = {final_byte, push_keep, asm_next};

    // Keep follows the lane being filled: a full word only pushes from lane 3.
    always_comb begin
        asm_next  = asm_q;
        push_keep = 4'b1111;
        case (lane)
            2'd0: begin asm_next[7:0]   = ciphertext_in_V_din; push_keep = 4'b0001; end
            2'd1: begin asm_next[15:8]  = ciphertext_in_V_din; push_keep = 4'b0011; end
            2'd2: begin asm_next[23:16] = ciphertext_in_V_din; push_keep = 4'b0111; end
            2'd3: begin asm_next[31:24] = ciphertext_in_V_din; push_keep = 4'b1111; end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state      <= S_IDLE;
            size_q     <= '0;
            asm_q      <= '0;
            byte_count <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (size_in == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            size_q     <= size_in;
                            byte_count <= '0;
                            asm_q      <= '0;
                            state      <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        byte_count <= bc_next;
                        asm_q      <= push_vld ? 32'd0 : asm_next;
                        if (final_byte) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The tlast beat is the only entry left once it handshakes.
                    if (m_tvalid && m_tready && m_tlast) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    rc4_word_fifo #(
        .W     (37),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (ap_clk),
        .rst_n  (ap_rst_n),
        .wr_vld (push_vld),
        .wr_dat (push_dat),
        .rd_vld (m_tvalid),
        .rd_rdy (m_tready),
        .rd_dat ({m_tlast, m_tkeep, m_tdata}),
        .count  (fifo_count)
    );
endmodule

// File: tb/tb_rc4_cipher_packer.sv
// Randomized bench for rc4_cipher_packer: byte streams are framed into expected
// words by a queue model and compared against every handshaken output beat.
module tb_rc4_cipher_packer;
    logic        ap_clk;
    logic        ap_rst_n;
    logic        start;
    logic [31:0] size_in;
    logic        busy;
    logic        done;
    logic [31:0] byte_count;
    logic [7:0]  din;
    logic        full_n;
    logic        write;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  bytes_q[$];
    logic [36:0] exp_q[$];
    int          bc_exp   = 0;
    int          feed_idx = 0;
    int          rdy_pct  = 100;
    bit          done_pending = 0;
    bit          hold = 0;
    logic [36:0] held;

    rc4_cipher_packer #(.FIFO_DEPTH(4)) dut (
        .ap_clk                 (ap_clk),
        .ap_rst_n               (ap_rst_n),
        .start                  (start),
        .size_in                (size_in),
        .busy                   (busy),
        .done                   (done),
        .byte_count             (byte_count),
        .ciphertext_in_V_din    (din),
        .ciphertext_in_V_full_n (full_n),
        .ciphertext_in_V_write  (write),
        .m_tdata                (m_tdata),
        .m_tkeep                (m_tkeep),
        .m_tlast                (m_tlast),
        .m_tvalid               (m_tvalid),
        .m_tready               (m_tready)
    );

    initial ap_clk = 0;
    always #5 ap_clk = ~ap_clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge ap_clk) begin
        #1;
        m_tready = ($urandom_range(99) < rdy_pct);
    end

    // Beat scoreboard, output stability and done-timing model.
    always @(negedge ap_clk) begin
        logic [36:0] cur;
        logic [36:0] e;
        cur = {m_tlast, m_tkeep, m_tdata};
        if (!ap_rst_n) begin
            exp_q.delete();
            done_pending = 0;
            hold = 0;
        end else begin
            check_eq("done_timing", done, done_pending);
            if (hold) begin
                check_eq("hold_valid", m_tvalid, 1);
                check_eq("hold_beat", cur, held);
            end
            done_pending = start && !busy && (size_in == 0);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("beat_unexpected", m_tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat", cur, e);
                    if (m_tlast) done_pending = 1;
                end
            end
            hold = m_tvalid && !m_tready;
            held = cur;
        end
    end

    task automatic load_random(input int sz);
        bytes_q.delete();
        for (int i = 0; i < sz; i++) bytes_q.push_back(8'($urandom_range(255)));
    endtask

    // Expected framing: 4 bytes per word little-endian, partial last word zero-padded.
    task automatic make_expected();
        int sz;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        sz = bytes_q.size();
        for (int w = 0; w * 4 < sz; w++) begin
            d = '0;
            k = '0;
            for (int b = 0; b < 4; b++) begin
                if (w * 4 + b < sz) begin
                    d[8*b +: 8] = bytes_q[w * 4 + b];
                    k[b] = 1'b1;
                end
            end
            l = (w * 4 + 4 >= sz);
            exp_q.push_back({l, k, d});
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_full_n"}, full_n, 0);
        check_eq({tag, "_tvalid"}, m_tvalid, 0);
        check_eq({tag, "_tdata"}, m_tdata, 0);
        check_eq({tag, "_tkeep"}, m_tkeep, 0);
        check_eq({tag, "_tlast"}, m_tlast, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_byte_count"}, byte_count, 0);
    endtask

    task automatic do_start(input int sz);
        @(posedge ap_clk); #1;
        start = 1;
        size_in = sz;
        if (sz > 0) begin
            bc_exp = 0;
            feed_idx = 0;
        end
        @(posedge ap_clk); #1;
        start = 0;
        @(negedge ap_clk);
        if (sz > 0) begin
            check_eq("start_busy", busy, 1);
            check_eq("start_full_n", full_n, 1);
        end else begin
            check_eq("zero_done", done, 1);
            check_eq("zero_busy", busy, 0);
            check_eq("zero_full_n", full_n, 0);
            check_eq("zero_tvalid", m_tvalid, 0);
        end
        @(posedge ap_clk); #1;
    endtask

    // Offers bytes until `target` are accepted or the cycle budget runs out.
    task automatic feed(input int target, input int wr_pct, input int max_cyc);
        int cyc = 0;
        while (feed_idx < target && cyc < max_cyc) begin
            write = ($urandom_range(99) < wr_pct);
            din = write ? bytes_q[feed_idx] : 8'($urandom_range(255));
            @(negedge ap_clk);
            check_eq("byte_count", byte_count, bc_exp);
            if (write && full_n) begin
                feed_idx++;
                bc_exp++;
            end
            @(posedge ap_clk); #1;
            cyc++;
        end
        write = 0;
    endtask

    task automatic wait_done(input int sz);
        int cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge ap_clk);
            cyc++;
        end
        check_eq("done_seen", done, 1);
        check_eq("byte_count_final", byte_count, sz);
        check_eq("busy_after_done", busy, 0);
        check_eq("words_left", exp_q.size(), 0);
    endtask

    task automatic run_xfer(input int sz, input int wr_pct, input int rp);
        rdy_pct = rp;
        make_expected();
        do_start(sz);
        feed(sz, wr_pct, 4000);
        check_eq("fed_all", feed_idx, sz);
        wait_done(sz);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] head8 [8];
        logic [7:0] tail4 [4];
        head8 = '{8'h22, 8'h80, 8'hc9, 8'h67, 8'h6c, 8'h8f, 8'h5c, 8'h52};
        tail4 = '{8'hbf, 8'hc5, 8'hf1, 8'h79};
        ap_rst_n = 0; start = 0; size_in = 0; din = 0; write = 0; m_tready = 0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check_reset("init");
        @(posedge ap_clk); #1;
        ap_rst_n = 1;

        // 32-byte transfer with known head/tail ciphertext.
        load_random(32);
        for (int i = 0; i < 8; i++) bytes_q[i] = head8[i];
        for (int i = 0; i < 4; i++) bytes_q[28 + i] = tail4[i];
        run_xfer(32, 100, 100);

        // 5-byte transfer: one full word then a 1-byte tail.
        bytes_q.delete();
        for (int i = 0; i < 5; i++) bytes_q.push_back(head8[i]);
        run_xfer(5, 100, 100);

        // Consumer stalled: input must stop after FIFO_DEPTH words.
        rdy_pct = 0;
        load_random(32);
        make_expected();
        do_start(32);
        feed(32, 100, 40);
        check_eq("stall_accepted", feed_idx, 16);
        @(negedge ap_clk);
        check_eq("stall_full_n", full_n, 0);
        @(posedge ap_clk); #1;
        rdy_pct = 100;
        feed(32, 100, 500);
        check_eq("stall_fed_all", feed_idx, 32);
        wait_done(32);

        // Zero-length transfer.
        do_start(0);
        repeat (3) begin
            @(negedge ap_clk);
            check_eq("zero_idle_busy", busy, 0);
            check_eq("zero_idle_full_n", full_n, 0);
            check_eq("zero_idle_tvalid", m_tvalid, 0);
        end

        // Writes beyond size are ignored.
        rdy_pct = 0;
        load_random(4);
        make_expected();
        do_start(4);
        feed(4, 100, 100);
        check_eq("x4_fed", feed_idx, 4);
        repeat (3) begin
            write = 1;
            din = 8'haa;
            @(negedge ap_clk);
            check_eq("extra_full_n", full_n, 0);
            check_eq("extra_byte_count", byte_count, 4);
            @(posedge ap_clk); #1;
        end
        write = 0;
        rdy_pct = 100;
        wait_done(4);

        // Reset after 6 of 32 bytes, consumer stalled so nothing leaves.
        rdy_pct = 0;
        load_random(32);
        make_expected();
        do_start(32);
        feed(6, 100, 50);
        check_eq("rst_fed6", feed_idx, 6);
        ap_rst_n = 0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1;
        bc_exp = 0;
        @(negedge ap_clk);
        check_reset("midrst");
        @(posedge ap_clk); #1;
        load_random(4);
        run_xfer(4, 100, 100);

        // Random sizes, write duty cycles and consumer readiness.
        for (int t = 0; t < 12; t++) begin
            int sz;
            sz = $urandom_range(40, 1);
            load_random(sz);
            run_xfer(sz, $urandom_range(100, 30), $urandom_range(100, 30));
        end

        repeat (2) @(posedge ap_clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
